// File: rtl/ps_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps_pkg
// Purpose : Shared types and geometry defaults for the pixel-stream blocks.
// Rev     : 1.0
// ============================================================================
package ps_pkg;

    localparam int c_default_line_length = 640;
    localparam int c_default_line_count  = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ps_kernel_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ps_kernel_sequencer
// Purpose : Frame sequencer feeding a line-buffer kernel block: frame pixels,
//           zero flush lines, then drain until every kernel output is seen.
// Rev     : 1.0
// ============================================================================
module ps_kernel_sequencer
    import ps_pkg::*;
#(
    parameter int LINE_LENGTH = c_default_line_length,
    parameter int LINE_COUNT  = c_default_line_count,
    parameter int DATA_WIDTH  = 1,
    parameter int FLUSH_LINES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_req,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_kvalid,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err_sof,
    input  logic                  i_clr_err
);

    localparam int PIX_W  = $clog2(LINE_LENGTH) + 1;
    localparam int LINE_W = $clog2(LINE_COUNT + FLUSH_LINES) + 1;
    localparam int OUT_W  = $clog2(LINE_LENGTH * LINE_COUNT) + 1;

    localparam logic [PIX_W-1:0]  c_pix_last   = PIX_W'(LINE_LENGTH - 1);
    localparam logic [LINE_W-1:0] c_feed_last  = LINE_W'(LINE_COUNT - 1);
    localparam logic [LINE_W-1:0] c_flush_last = LINE_W'(FLUSH_LINES - 1);
    localparam logic [OUT_W-1:0]  c_out_total  = OUT_W'(LINE_LENGTH * LINE_COUNT);

    seq_state_t            r_state;
    logic [PIX_W-1:0]      r_pix;
    logic [LINE_W-1:0]     r_line;
    logic [OUT_W-1:0]      r_out_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;

    logic w_line_go;
    logic w_feed_beat;
    logic w_flush_beat;
    logic w_beat;
    logic w_pix_last;
    logic w_busy;

    // A line may only begin while i_req is high; once pixel 0 is taken the
    // line runs to completion, so a nonzero pixel count means "line started".
    assign w_line_go    = (r_pix != '0) || i_req;
    assign w_feed_beat  = (r_state == ST_FEED) && w_line_go && i_valid;
    assign w_flush_beat = (r_state == ST_FLUSH) && w_line_go;
    assign w_beat       = w_feed_beat || w_flush_beat;
    assign w_pix_last   = (r_pix == c_pix_last);
    assign w_busy       = (r_state != ST_IDLE);

    assign o_ready      = (r_state == ST_FEED) && w_line_go;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_busy       = w_busy;
    assign o_frame_done = (r_state == ST_DONE);
    assign o_err_sof    = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_pix     <= '0;
            r_line    <= '0;
            r_out_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_beat;
            if (w_beat) begin
                r_data <= w_feed_beat ? i_data : '0;
                r_pix  <= w_pix_last ? '0 : r_pix + 1'b1;
            end
            if (w_busy && i_kvalid && (r_out_cnt != c_out_total)) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            // A stray start pulse beats a simultaneous clear.
            r_err <= (r_err & ~i_clr_err) | (i_sof & w_busy);

            case (r_state)
                ST_IDLE: begin
                    if (i_sof) begin
                        r_state   <= ST_FEED;
                        r_pix     <= '0;
                        r_line    <= '0;
                        r_out_cnt <= '0;
                    end
                end
                ST_FEED: begin
                    if (w_feed_beat && w_pix_last) begin
                        if (r_line == c_feed_last) begin
                            r_line  <= '0;
                            r_state <= (FLUSH_LINES == 0) ? ST_DRAIN : ST_FLUSH;
                        end else begin
                            r_line <= r_line + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_beat && w_pix_last) begin
                        if (r_line == c_flush_last) begin
                            r_line  <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_line <= r_line + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_out_cnt == c_out_total) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
